// File: rtl/pll_reconfig_ctrl.sv
// Sequencer for single-byte PLL reconfiguration reads/writes and PLL reset/lock handling.
// All outputs are registered from the next-state decode.
module pll_reconfig_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_i,
  input  logic       req_we_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  input  logic       req_apply_i,
  output logic       busy_o,
  output logic       ack_o,
  output logic [7:0] rdata_o,
  output logic       err_o,
  output logic       lock_lost_o,
  output logic       locked_o,
  output logic [1:0] mdopc_o,
  output logic       mdainc_o,
  output logic [7:0] mdwdi_o,
  input  logic [7:0] mdrdo_i,
  output logic       pll_reset_o,
  input  logic       pll_lock_i
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StOp, StRdCap, StRst, StWaitLock, StDone
  } state_e;

  localparam logic [15:0] RstLast  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LockLast = 16'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        apply_q, apply_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        lock_lost_q, lock_lost_d;
  logic        locked_q, locked_d;
  logic [1:0]  mdopc_q, mdopc_d;
  logic [7:0]  mdwdi_q, mdwdi_d;
  logic        pll_reset_q, pll_reset_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        sync1_q, sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    apply_d     = apply_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    lock_lost_d = lock_lost_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d        = req_we_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          apply_d     = req_apply_i;
          err_d       = 1'b0;
          lock_lost_d = 1'b0;
          state_d     = StAddr;
        end else if (sync2_q && !sync1_q) begin
          // sync2 is about to fall: lock dropped while idle
          lock_lost_d = 1'b1;
        end
      end
      StAddr: state_d = StOp;
      StOp: begin
        if (!we_q) begin
          state_d = StRdCap;
        end else if (apply_q) begin
          state_d = StRst;
          cnt_d   = '0;
        end else begin
          state_d = StDone;
        end
      end
      StRdCap: begin
        rdata_d = mdrdo_i;
        cnt_d   = '0;
        state_d = apply_q ? StRst : StDone;
      end
      StRst: begin
        if (cnt_q == RstLast) begin
          cnt_d   = '0;
          state_d = StWaitLock;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitLock: begin
        if (sync2_q) begin
          state_d = StDone;
        end else if (cnt_q == LockLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        state_d = StRst;
        cnt_d   = '0;
      end
    endcase

    mdopc_d = 2'b00;
    mdwdi_d = 8'h00;
    if (state_d == StAddr) begin
      mdopc_d = 2'b11;
      mdwdi_d = addr_d;
    end else if (state_d == StOp) begin
      mdopc_d = we_q ? 2'b01 : 2'b10;
      mdwdi_d = we_q ? wdata_q : 8'h00;
    end
    pll_reset_d = (state_d == StRst);
    ack_d       = (state_d == StDone);
    busy_d      = (state_d != StIdle);
    // sync1 registered here lines up with sync2, so locked lags the raw lock by two cycles
    locked_d    = sync1_q && !(state_d inside {StRst, StWaitLock});
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StRst;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      apply_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lock_lost_q <= 1'b0;
      locked_q    <= 1'b0;
      mdopc_q     <= 2'b00;
      mdwdi_q     <= '0;
      pll_reset_q <= 1'b1;
      ack_q       <= 1'b0;
      busy_q      <= 1'b1;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      apply_q     <= apply_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      lock_lost_q <= lock_lost_d;
      locked_q    <= locked_d;
      mdopc_q     <= mdopc_d;
      mdwdi_q     <= mdwdi_d;
      pll_reset_q <= pll_reset_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      sync1_q     <= pll_lock_i;
      sync2_q     <= sync1_q;
    end
  end

  assign busy_o      = busy_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign lock_lost_o = lock_lost_q;
  assign locked_o    = locked_q;
  assign mdopc_o     = mdopc_q;
  assign mdainc_o    = 1'b0;
  assign mdwdi_o     = mdwdi_q;
  assign pll_reset_o = pll_reset_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: PLL port model plus a schedule-based reference.
module tb_pll_reconfig_ctrl;
  localparam int R     = 16;
  localparam int T     = 100;
  localparam int NEVER = 1_000_000_000;

  logic       clk, reset_i, req_i, req_we_i, req_apply_i;
  logic [7:0] req_addr_i, req_wdata_i, mdrdo, mdwdi_o, rdata_o;
  logic       busy_o, ack_o, err_o, lock_lost_o, locked_o, mdainc_o, pll_reset_o, pll_lock;
  logic [1:0] mdopc_o;

  int n_cmp = 0;
  int n_bad = 0;

  pll_reconfig_ctrl #(.RST_CYCLES(R), .LOCK_TIMEOUT(T)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_apply_i (req_apply_i),
    .busy_o      (busy_o),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .lock_lost_o (lock_lost_o),
    .locked_o    (locked_o),
    .mdopc_o     (mdopc_o),
    .mdainc_o    (mdainc_o),
    .mdwdi_o     (mdwdi_o),
    .mdrdo_i     (mdrdo),
    .pll_reset_o (pll_reset_o),
    .pll_lock_i  (pll_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PLL model: register file behind the md port, lock rises lock_delay cycles after reset falls
  logic [7:0] pll_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] pll_addr;
  int  lcnt       = 0;
  int  lock_delay = 24;
  bit  force_low  = 1'b0;

  always @(negedge clk) begin
    #1;
    if (pll_reset_o === 1'b1) begin
      lcnt     = 0;
      pll_lock = 1'b0;
    end else begin
      if (force_low) pll_lock = 1'b0;
      else if (lcnt >= lock_delay) pll_lock = 1'b1;
      if (lcnt < 10_000_000) lcnt++;
    end
    case (mdopc_o)
      2'b11:   pll_addr = mdwdi_o;
      2'b01:   pll_mem[pll_addr] = mdwdi_o;
      2'b10:   mdrdo = pll_mem[pll_addr];
      default: ;
    endcase
  end

  logic [7:0] rdata_ref  = 8'h00;
  bit         locked_exp = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the cycle after acceptance (or after reset release when has_op=0).
  task automatic run_trace(input bit has_op, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, input bit apply, input int L, input bit inj);
    int t, ack_c;
    bit ap, tmo;
    logic [1:0] e_opc;
    logic [7:0] e_wdi, e_rd;
    t  = has_op ? (we ? 2 : 3) : 0;
    ap = has_op ? apply : 1'b1;
    if (ap) lock_delay = L;
    if (!ap) begin
      ack_c = t; tmo = 1'b0;
    end else if (L + 3 <= T) begin
      ack_c = t + R + L + 3; tmo = 1'b0;
    end else begin
      ack_c = t + R + T; tmo = 1'b1;
    end
    for (int n = 0; n <= ack_c; n++) begin
      e_opc = 2'b00;
      e_wdi = 8'h00;
      if (has_op && n == 0) begin
        e_opc = 2'b11; e_wdi = addr;
      end else if (has_op && n == 1) begin
        e_opc = we ? 2'b01 : 2'b10; e_wdi = we ? wdata : 8'h00;
      end
      e_rd = (has_op && !we && n >= 3) ? ref_mem[addr] : rdata_ref;
      check_val($sformatf("mdopc@%0d", n), mdopc_o, e_opc);
      check_val($sformatf("mdwdi@%0d", n), mdwdi_o, e_wdi);
      check_val($sformatf("pll_reset@%0d", n), pll_reset_o, ap && n >= t && n < t + R);
      check_val($sformatf("ack@%0d", n), ack_o, n == ack_c);
      check_val($sformatf("busy@%0d", n), busy_o, 1'b1);
      check_val($sformatf("err@%0d", n), err_o, (n == ack_c) ? tmo : 1'b0);
      check_val($sformatf("lock_lost@%0d", n), lock_lost_o, 1'b0);
      check_val($sformatf("rdata@%0d", n), rdata_o, e_rd);
      if (n == 0) check_val("mdainc", mdainc_o, 1'b0);
      if (inj && ap && n == t + 1) begin
        req_i = 1'b1; req_we_i = $urandom; req_addr_i = $urandom;
        req_wdata_i = $urandom; req_apply_i = $urandom;
      end
      if (n == t + 2) req_i = 1'b0;
      @(negedge clk);
    end
    if (has_op && !we) rdata_ref = ref_mem[addr];
    if (ap) locked_exp = !tmo;
    check_val("busy_end", busy_o, 1'b0);
    check_val("ack_end", ack_o, 1'b0);
    check_val("err_end", err_o, tmo);
    check_val("locked_end", locked_o, locked_exp);
    check_val("rdata_end", rdata_o, rdata_ref);
  endtask

  task automatic issue(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                       input bit apply, input int L, input bit inj);
    req_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_apply_i = apply;
    @(negedge clk);
    req_i = 1'b0; req_we_i = $urandom; req_addr_i = $urandom; req_wdata_i = $urandom;
    run_trace(1'b1, we, addr, wdata, apply, L, inj);
    if (we) ref_mem[addr] = wdata;
  endtask

  initial begin
    logic [7:0] v;
    bit we, ap, inj;
    int L;
    reset_i = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_apply_i = 1'b0; pll_lock = 1'b0; mdrdo = '0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom); pll_mem[i] = v; ref_mem[i] = v;
    end
    pll_mem[8'h07] = 8'hC3; ref_mem[8'h07] = 8'hC3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_pll_reset", pll_reset_o, 1'b1);
    check_val("rst_busy", busy_o, 1'b1);
    check_val("rst_ack", ack_o, 1'b0);
    check_val("rst_rdata", rdata_o, 8'h00);
    check_val("rst_err", err_o, 1'b0);
    check_val("rst_lock_lost", lock_lost_o, 1'b0);
    check_val("rst_locked", locked_o, 1'b0);
    check_val("rst_mdopc", mdopc_o, 2'b00);
    check_val("rst_mdwdi", mdwdi_o, 8'h00);
    reset_i = 1'b0;
    run_trace(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 24, 1'b0);

    issue(1'b1, 8'h12, 8'h5A, 1'b0, 0, 1'b0);
    issue(1'b0, 8'h07, 8'h00, 1'b0, 0, 1'b0);
    issue(1'b1, 8'h21, 8'h9C, 1'b1, NEVER, 1'b1);
    issue(1'b0, 8'h21, 8'h00, 1'b0, 0, 1'b0);
    issue(1'b1, 8'h30, 8'h11, 1'b1, 3, 1'b1);

    // lock glitch in idle: five cycles low
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) force_low = 1'b1;
      if (k == 5) force_low = 1'b0;
      check_val($sformatf("glitch_locked@%0d", k), locked_o, (k < 2) || (k >= 7));
      check_val($sformatf("glitch_lock_lost@%0d", k), lock_lost_o, k >= 2);
      check_val($sformatf("glitch_busy@%0d", k), busy_o, 1'b0);
      @(negedge clk);
    end
    issue(1'b0, 8'h12, 8'h00, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      we  = 1'($urandom);
      ap  = ($urandom_range(0, 2) == 0);
      L   = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 60));
      inj = 1'($urandom);
      issue(we, 8'($urandom), 8'($urandom), ap, L, inj);
    end

    // reset while waiting for lock: no ack, fresh restart
    req_i = 1'b1; req_we_i = 1'b1; req_addr_i = 8'h33; req_wdata_i = 8'h44; req_apply_i = 1'b1;
    lock_delay = NEVER;
    @(negedge clk);
    req_i = 1'b0;
    for (int n = 0; n < 2 + R + 10; n++) begin
      check_val($sformatf("abort_ack@%0d", n), ack_o, 1'b0);
      @(negedge clk);
    end
    ref_mem[8'h33] = 8'h44;
    reset_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check_val($sformatf("abort_rst_ack@%0d", n), ack_o, 1'b0);
      check_val($sformatf("abort_rst_pll_reset@%0d", n), pll_reset_o, 1'b1);
    end
    reset_i = 1'b0;
    rdata_ref = 8'h00;
    run_trace(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 20, 1'b0);
    issue(1'b0, 8'h33, 8'h00, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
